// File: rtl/fact_bcd_conv.sv
// -----------------------------------------------------------------------------
// fact_bcd_conv
//
// Sequential binary-to-BCD converter for the factorial stage result. It uses
// shift-and-add-3 (double-dabble) and processes one binary bit per clock. It
// also reports how many decimal digits are significant, so the readout stage
// can blank leading zeros.
//
// DIGITS must be large enough that 10^DIGITS > 2^(WIDTH*11).
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request a conversion of facto (sampled only while idle)
//   facto    binary value from the factorial stage, captured on accepted start
//   busy     high while a conversion is in progress
//   done     one-cycle pulse when bcd/ndigits update
//   bcd      packed BCD result, digit 0 in bits [3:0]
//   ndigits  number of significant digits (1..DIGITS); 0 only out of reset
// -----------------------------------------------------------------------------
module fact_bcd_conv #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH*11-1:0]    facto,
  output logic                   busy,
  output logic                   done,
  output logic [DIGITS*4-1:0]    bcd,
  output logic [3:0]             ndigits
);

  localparam int BIN_W = WIDTH * 11;
  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   scratch_adj;
  logic [CNT_W-1:0]   bit_cnt;

  // Position of the highest nonzero digit plus one; an all-zero value still
  // shows a single "0" digit.
  function automatic logic [3:0] sig_digits(input logic [BCD_W-1:0] v);
    logic [3:0] n;
    n = 4'd1;
    for (int i = 1; i < DIGITS; i++) begin
      if (v[i*4 +: 4] != 4'd0) n = 4'(i + 1);
    end
    return n;
  endfunction

  // Add-3 correction on every digit in parallel, ahead of the shift. A digit
  // of 5..9 becomes 8..12, so after doubling it carries into the next digit
  // and no digit ever holds 10..15.
  always_comb begin
    // NOTE: default assignment first so every path drives scratch_adj and no
    // latch is inferred.
    scratch_adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5) scratch_adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
    end
  end

  // Next-state logic. The counter holds the number of shifts still to do, so
  // the shift taken with bit_cnt == 1 is the last one.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == CNT_W'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and datapath. busy is decoded from the next state, so it
  // is a true register output that is already high in the first SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      ndigits <= '0;
      bin_sr  <= '0;
      scratch <= '0;
      bit_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, whatever the statement order.
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= facto;
            scratch <= '0;
            bit_cnt <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          // The binary MSB enters bit 0 of scratch digit 0.
          {scratch, bin_sr} <= {scratch_adj[BCD_W-2:0], bin_sr, 1'b0};
          bit_cnt           <= bit_cnt - CNT_W'(1);
        end
        FINISH: begin
          bcd     <= scratch;
          ndigits <= sig_digits(scratch);
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_bcd_conv.sv
// -----------------------------------------------------------------------------
// tb_fact_bcd_conv
//
// Scoreboard bench for fact_bcd_conv. Each accepted start pushes the expected
// BCD digits, the significant-digit count and the cycle in which done is due.
// The expected values come from a decimal reference model that uses repeated
// division by ten. A monitor on the falling edge pops and compares the queue
// on every done. It also flags any change of bcd/ndigits outside done, done in
// two consecutive cycles, and any done with nothing outstanding.
// -----------------------------------------------------------------------------
module tb_fact_bcd_conv;

  localparam int WIDTH  = 4;
  localparam int DIGITS = 14;
  localparam int BIN_W  = WIDTH * 11;
  localparam int BCD_W  = DIGITS * 4;
  // From the tb drive point (1 ns after edge N) to the monitor sample:
  // start is sampled at edge N+1, and done is visible after edge N+1+BIN_W+1.
  localparam int LAT    = BIN_W + 2;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [BIN_W-1:0]  facto = '0;
  logic              busy;
  logic              done;
  logic [BCD_W-1:0]  bcd;
  logic [3:0]        ndigits;

  fact_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .facto   (facto),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd),
    .ndigits (ndigits)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BCD_W-1:0] bcd;
    logic [3:0]       nd;
    int               due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain decimal arithmetic on the binary value.
  function automatic exp_t model(input logic [BIN_W-1:0] v);
    exp_t            r;
    longint unsigned x;
    int              nd;
    r.bcd = '0;
    x = 64'(v);
    for (int i = 0; i < DIGITS; i++) begin
      r.bcd[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    x  = 64'(v);
    nd = 0;
    do begin
      nd++;
      x = x / 10;
    end while (x != 0);
    r.nd  = 4'(nd);
    r.due = 0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for idle, push the expectation, pulse start for one edge, and then
  // scramble facto to show that it is not re-sampled after capture.
  task automatic issue(input logic [BIN_W-1:0] v);
    exp_t e;
    int   guard;
    guard = 0;
    while (busy && guard < 200) begin
      tick();
      guard++;
    end
    check("issue_wait_idle", 64'(busy), 0);
    e     = model(v);
    e.due = cyc + LAT;
    sb.push_back(e);
    facto = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    facto = BIN_W'({$urandom, $urandom});
    check("busy_after_start", 64'(busy), 1);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((busy || sb.size() != 0) && guard < 500) begin
      tick();
      guard++;
    end
    check("drain_queue_empty", 64'(sb.size()), 0);
  endtask

  // Monitor / scoreboard.
  exp_t             mon_e;
  logic             prev_done = 1'b0;
  logic [BCD_W-1:0] prev_bcd  = '0;
  logic [3:0]       prev_nd   = '0;
  logic             bad_digit;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        check("done_not_consecutive", 64'(prev_done), 0);
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
          if (bcd[i*4 +: 4] > 4'd9) bad_digit = 1'b1;
        end
        check("digit_le_9", 64'(bad_digit), 0);
        if (sb.size() == 0) begin
          check("unexpected_done_outstanding", 64'(sb.size()), 1);
        end else begin
          mon_e = sb.pop_front();
          check("bcd_value", 64'(bcd), 64'(mon_e.bcd));
          check("ndigits_value", 64'(ndigits), 64'(mon_e.nd));
          check("done_latency_cycle", 64'(cyc), 64'(mon_e.due));
        end
      end else begin
        check("bcd_hold", 64'(bcd), 64'(prev_bcd));
        check("ndigits_hold", 64'(ndigits), 64'(prev_nd));
      end
    end
    prev_done = done;
    prev_bcd  = bcd;
    prev_nd   = ndigits;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    logic [BIN_W-1:0] v;
    int guard;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 0);
    check("reset_done", 64'(done), 0);
    check("reset_bcd", 64'(bcd), 0);
    check("reset_ndigits", 64'(ndigits), 0);
    rst_n = 1'b1;
    tick();

    // Directed values from the factorial stage.
    issue('0);                         wait_drain();
    check("zero_ndigits", 64'(ndigits), 1);
    issue(BIN_W'(120));                wait_drain();
    check("fact5_bcd", 64'(bcd), 64'h120);
    issue(BIN_W'(64'd1307674368000));  wait_drain();
    check("fact15_ndigits", 64'(ndigits), 13);
    issue({BIN_W{1'b1}});              wait_drain();
    check("max_bcd", 64'(bcd), 64'h17592186044415);
    check("max_ndigits", 64'(ndigits), 14);

    // A start during a conversion is ignored; a start in the done cycle is
    // accepted.
    issue(BIN_W'(24));
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!done && guard < 100) begin
      tick();
      guard++;
    end
    check("done_seen_for_24", 64'(done), 1);
    check("bcd_24", 64'(bcd), 64'h24);
    issue(BIN_W'(720));
    repeat (20) tick();
    check("bcd_holds_24", 64'(bcd), 64'h24);
    wait_drain();
    check("bcd_720", 64'(bcd), 64'h720);

    // Asynchronous reset at shift 20 aborts the conversion.
    issue(BIN_W'(5040));
    repeat (19) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_bcd", 64'(bcd), 0);
    check("abort_ndigits", 64'(ndigits), 0);
    check("abort_busy", 64'(busy), 0);
    check("abort_done", 64'(done), 0);
    sb.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (60) tick();
    check("no_done_after_abort_bcd", 64'(bcd), 0);
    issue(BIN_W'(5040));
    wait_drain();
    check("bcd_5040", 64'(bcd), 64'h5040);
    check("ndigits_5040", 64'(ndigits), 4);

    // Random values of varied magnitude: mostly back-to-back, some with gaps.
    for (int n = 0; n < 30; n++) begin
      r = {$urandom, $urandom};
      v = BIN_W'(r) >> $urandom_range(0, BIN_W - 1);
      issue(v);
      if ($urandom_range(0, 3) == 0) begin
        wait_drain();
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
